// File: rtl/dpram_pkg.sv
// Shared sizing constants for the FIFO dual-port RAM read-side controller.
package dpram_pkg;

    localparam int DATESIZE  = 8;
    localparam int ADDRSIZE  = 4;
    localparam int DEPTH     = 1 << ADDRSIZE;
    localparam int OUT_DEPTH = 2;
    localparam int PTR_W     = ADDRSIZE + 1;

endpackage

// File: rtl/dpram_rd_ctrl_if.sv
// Pointer, RAM port B and output stream signals of the read controller.
// Optional rd_level signal is present when DPRAM_RD_LEVEL_EN is defined.
interface dpram_rd_ctrl_if #(
    parameter int DATESIZE = dpram_pkg::DATESIZE,
    parameter int ADDRSIZE = dpram_pkg::ADDRSIZE
);

    logic [ADDRSIZE:0]   wr_ptr;
    logic [ADDRSIZE:0]   rd_ptr;
    logic                ram_en;
    logic [ADDRSIZE-1:0] ram_addr;
    logic [DATESIZE-1:0] ram_dout;
    logic                m_valid;
    logic                m_ready;
    logic [DATESIZE-1:0] m_data;
`ifdef DPRAM_RD_LEVEL_EN
    logic [ADDRSIZE+1:0] rd_level;
`endif

    // master: the read controller; slave: writer, RAM and downstream sink.
    modport master (
        input  wr_ptr, ram_dout, m_ready,
        output rd_ptr, ram_en, ram_addr, m_valid, m_data
`ifdef DPRAM_RD_LEVEL_EN
        , output rd_level
`endif
    );

    modport slave (
        output wr_ptr, ram_dout, m_ready,
        input  rd_ptr, ram_en, ram_addr, m_valid, m_data
`ifdef DPRAM_RD_LEVEL_EN
        , input rd_level
`endif
    );

endinterface

// File: rtl/rd_out_buf.sv
// Two-entry push/pop register buffer; slot0 is always the head word.
module rd_out_buf #(
    parameter int DATESIZE = dpram_pkg::DATESIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push_i,
    input  logic [DATESIZE-1:0] push_data_i,
    input  logic                pop_i,
    output logic [1:0]          count_o,
    output logic                valid_o,
    output logic [DATESIZE-1:0] head_o
);

    logic [DATESIZE-1:0] slot0_q, slot0_d;
    logic [DATESIZE-1:0] slot1_q, slot1_d;
    logic [1:0]          cnt_q, cnt_d;

    always_comb begin
        // NOTE: every next-state value gets a default first so no latch is inferred.
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        cnt_d   = cnt_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) slot0_d = push_data_i;
                else               slot1_d = push_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                slot0_d = slot1_q;
                cnt_d   = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    slot0_d = push_data_i;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 2'd0;
            // NOTE: the two data slots are reset too, so m_data reads 0 out of reset.
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all registered state.
            cnt_q   <= cnt_d;
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = slot0_q;

endmodule

// File: rtl/dpram_rd_ctrl.sv
// Read-side controller for the FIFO dual-port RAM with a first-word-fall-through output.
// Define DPRAM_RD_LEVEL_EN to add the registered rd_level occupancy output.
module dpram_rd_ctrl #(
    parameter int DATESIZE = dpram_pkg::DATESIZE,
    parameter int ADDRSIZE = dpram_pkg::ADDRSIZE
) (
    input  logic            clk,
    input  logic            rst,
    dpram_rd_ctrl_if.master bus
);

    import dpram_pkg::*;

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                inflight_q, inflight_d;
    logic [PW-1:0]       avail;
    logic [2:0]          occ;
    logic                pop;
    logic                issue;
    logic [1:0]          buf_cnt;
    logic                buf_valid;
    logic [DATESIZE-1:0] buf_head;

    // A read is only issued when the word has a guaranteed slot once it lands,
    // counting the slot freed by a pop in this same cycle.
    always_comb begin
        avail      = bus.wr_ptr - rd_ptr_q;
        pop        = buf_valid & bus.m_ready;
        occ        = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = (avail != '0) && (occ < 3'(OUT_DEPTH));
        rd_ptr_d   = rd_ptr_q + PW'(issue);
        inflight_d = issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    rd_out_buf #(
        .DATESIZE(DATESIZE)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_data_i(bus.ram_dout),
        .pop_i      (pop),
        .count_o    (buf_cnt),
        .valid_o    (buf_valid),
        .head_o     (buf_head)
    );

    assign bus.rd_ptr   = rd_ptr_q;
    assign bus.ram_en   = issue;
    assign bus.ram_addr = rd_ptr_q[ADDRSIZE-1:0];
    assign bus.m_valid  = buf_valid;
    assign bus.m_data   = buf_head;

`ifdef DPRAM_RD_LEVEL_EN
    localparam int LW = ADDRSIZE + 2;

    logic [LW-1:0] level_q, level_d;

    // Words not yet delivered: still in RAM, in flight, or buffered.
    always_comb begin
        level_d = LW'(avail) + LW'(inflight_q) + LW'(buf_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) level_q <= '0;
        else     level_q <= level_d;
    end

    assign bus.rd_level = level_q;
`endif

endmodule
